// File: rtl/life_pkg.sv
// Shared constants, state encoding and cell indexing for the life engine.
package life_pkg;

    localparam int unsigned GRID_N    = 8;
    localparam int unsigned GRID_BITS = GRID_N * GRID_N;
    localparam int unsigned IDX_W     = $clog2(GRID_BITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } life_state_t;

    // Row-major bit index: row 0 occupies bits 7:0.
    function automatic logic [IDX_W-1:0] cell_idx(input int unsigned r, input int unsigned c);
        return IDX_W'(r * GRID_N + c);
    endfunction

endpackage

// File: rtl/life_next_gen.sv
// Combinational B3/S23 generation step over the 8x8 grid.
module life_next_gen
    import life_pkg::*;
#(
    parameter bit WRAP = 1'b0
) (
    input  logic [GRID_BITS-1:0] grid,
    output logic [GRID_BITS-1:0] next
);

    // Coordinates arrive biased by GRID_N so that an offset of -1 stays unsigned.
    function automatic logic cell_at(input logic [GRID_BITS-1:0] g,
                                     input int unsigned r, input int unsigned c);
        logic v;
        v = 1'b0;
        if (WRAP) begin
            v = g[cell_idx(r % GRID_N, c % GRID_N)];
        end else if (r >= GRID_N && r < 2 * GRID_N && c >= GRID_N && c < 2 * GRID_N) begin
            v = g[cell_idx(r - GRID_N, c - GRID_N)];
        end
        return v;
    endfunction

    // Count the eight neighbours of every cell and apply the survival/birth rule.
    always_comb begin
        logic [3:0] cnt;
        cnt  = '0;
        next = '0;
        for (int unsigned r = 0; r < GRID_N; r++) begin
            for (int unsigned c = 0; c < GRID_N; c++) begin
                cnt = '0;
                for (int unsigned dr = 0; dr < 3; dr++) begin
                    for (int unsigned dc = 0; dc < 3; dc++) begin
                        if (!(dr == 1 && dc == 1)) begin
                            cnt = cnt + {3'b000, cell_at(grid, r + dr + GRID_N - 1,
                                                               c + dc + GRID_N - 1)};
                        end
                    end
                end
                if (grid[cell_idx(r, c)]) begin
                    next[cell_idx(r, c)] = (cnt == 4'd2) || (cnt == 4'd3);
                end else begin
                    next[cell_idx(r, c)] = (cnt == 4'd3);
                end
            end
        end
    end

endmodule

// File: rtl/life_engine.sv
// Life engine: grid register, run/step control, generation counter and status.
module life_engine
    import life_pkg::*;
#(
    parameter int unsigned TICK_DIV = 12_500_000,
    parameter bit          WRAP     = 1'b0,
    parameter int unsigned GEN_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 run,
    input  logic                 step,
    input  logic [GRID_BITS-1:0] seed_in,
    output logic [GRID_BITS-1:0] grid,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 stable,
    output logic                 extinct
);

    localparam int unsigned     PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    life_state_t          state, state_nx;
    logic [PRE_W-1:0]     prescaler;
    logic [GRID_BITS-1:0] next;
    logic                 advance, pre_clr, pre_inc, settled;

    life_next_gen #(.WRAP(WRAP)) u_next_gen (
        .grid (grid),
        .next (next)
    );

    // An advance that reaches a fixed point or an empty grid ends the run.
    assign settled = (next == grid) || (next == '0);
    assign extinct = (grid == '0);

    // Next-state and advance decode; load overrides everything below reset.
    always_comb begin
        state_nx = state;
        advance  = 1'b0;
        pre_clr  = 1'b0;
        pre_inc  = 1'b0;
        case (state)
            IDLE, HOLD: begin
                advance = step;
                if (run) begin
                    state_nx = RUN;
                    pre_clr  = 1'b1;
                end
            end
            RUN: begin
                if (!run) begin
                    state_nx = HOLD;
                end else if (prescaler == PRE_LAST) begin
                    advance = 1'b1;
                    pre_clr = 1'b1;
                end else begin
                    pre_inc = 1'b1;
                end
            end
            default: ;
        endcase
        if (advance && settled) begin
            state_nx = DONE;
        end
        if (load) begin
            state_nx = run ? RUN : IDLE;
            advance  = 1'b0;
            pre_clr  = 1'b1;
            pre_inc  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Tick prescaler.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
        end else if (pre_clr) begin
            prescaler <= '0;
        end else if (pre_inc) begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Grid, saturating generation counter and stable flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grid      <= '0;
            gen_count <= '0;
            stable    <= 1'b0;
        end else if (load) begin
            grid      <= seed_in;
            gen_count <= '0;
            stable    <= 1'b0;
        end else if (advance) begin
            grid <= next;
            if (gen_count != '1) begin
                gen_count <= gen_count + 1'b1;
            end
            if (settled) begin
                stable <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_life_engine.sv
// Directed self-checking bench for life_engine (bordered and toroidal instances).
module tb_life_engine;

    logic        clk = 1'b0;
    logic        reset, load, run, step;
    logic [63:0] seed_in;
    logic [63:0] grid, grid_w;
    logic [15:0] gen_count, gen_count_w;
    logic        stable, stable_w, extinct, extinct_w;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
    localparam logic [63:0] CORNERS = 64'h8100_0000_0000_0081;

    typedef struct {
        logic [63:0] seed;
        logic [63:0] exp0;
        logic        stab0;
        logic [63:0] exp1;
        logic        stab1;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    life_engine #(.TICK_DIV(4), .WRAP(1'b0), .GEN_W(16)) dut (
        .clk(clk), .reset(reset), .load(load), .run(run), .step(step),
        .seed_in(seed_in), .grid(grid), .gen_count(gen_count),
        .stable(stable), .extinct(extinct)
    );

    life_engine #(.TICK_DIV(4), .WRAP(1'b1), .GEN_W(16)) dut_w (
        .clk(clk), .reset(reset), .load(load), .run(run), .step(step),
        .seed_in(seed_in), .grid(grid_w), .gen_count(gen_count_w),
        .stable(stable_w), .extinct(extinct_w)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [63:0] s);
        seed_in = s;
        load    = 1'b1;
        cyc(1);
        load    = 1'b0;
    endtask

    task automatic do_step();
        step = 1'b1;
        cyc(1);
        step = 1'b0;
    endtask

    initial begin
        vecs[0] = '{BLINK_H,             BLINK_V,      1'b0, BLINK_V,                  1'b0};
        vecs[1] = '{BLOCK,               BLOCK,        1'b1, BLOCK,                    1'b1};
        vecs[2] = '{64'h1,               64'h0,        1'b1, 64'h0,                    1'b1};
        vecs[3] = '{CORNERS,             64'h0,        1'b1, CORNERS,                  1'b1};
        vecs[4] = '{64'h0000_0000_0000_00FF, 64'h7E7E, 1'b0, 64'hFF00_0000_0000_FFFF,  1'b0};
        vecs[5] = '{64'h0000_0000_0000_0007, 64'h0202, 1'b0, 64'h0200_0000_0000_0202,  1'b0};

        reset = 1'b1; load = 1'b0; run = 1'b0; step = 1'b0; seed_in = '0;
        cyc(2);
        reset = 1'b0;
        cyc(1);
        check("reset_grid",    grid,            64'h0);
        check("reset_gen",     64'(gen_count),  64'h0);
        check("reset_stable",  64'(stable),     64'h0);
        check("reset_extinct", 64'(extinct),    64'h1);

        // One generation from each seed on both border modes.
        for (int i = 0; i < 6; i++) begin
            do_load(vecs[i].seed);
            check("tbl_load_grid",  grid,           vecs[i].seed);
            check("tbl_load_gen",   64'(gen_count), 64'h0);
            check("tbl_load_stab",  64'(stable),    64'h0);
            do_step();
            check("tbl_grid",       grid,           vecs[i].exp0);
            check("tbl_stable",     64'(stable),    64'(vecs[i].stab0));
            check("tbl_extinct",    64'(extinct),   64'(vecs[i].exp0 == 64'h0));
            check("tbl_gen",        64'(gen_count), 64'h1);
            check("tbl_grid_w",     grid_w,         vecs[i].exp1);
            check("tbl_stable_w",   64'(stable_w),  64'(vecs[i].stab1));
        end

        // Blinker oscillates back after two steps.
        do_load(BLINK_H);
        do_step();
        do_step();
        check("blink_grid",   grid,           BLINK_H);
        check("blink_gen",    64'(gen_count), 64'h2);
        check("blink_stable", 64'(stable),    64'h0);

        // Still life under run: first advance on the 4th edge after entering RUN.
        do_load(BLOCK);
        run = 1'b1;
        cyc(1);
        cyc(3);
        check("still_pre_gen",  64'(gen_count), 64'h0);
        check("still_pre_stab", 64'(stable),    64'h0);
        cyc(1);
        check("still_gen",      64'(gen_count), 64'h1);
        check("still_stable",   64'(stable),    64'h1);
        check("still_grid",     grid,           BLOCK);
        cyc(6);
        check("still_done_gen", 64'(gen_count), 64'h1);
        run = 1'b0;

        // Extinction lands in DONE; further step/run ignored.
        do_load(64'h1);
        do_step();
        check("ext_grid",    grid,           64'h0);
        check("ext_extinct", 64'(extinct),   64'h1);
        check("ext_stable",  64'(stable),    64'h1);
        do_step();
        run = 1'b1;
        cyc(6);
        run = 1'b0;
        check("ext_done_gen", 64'(gen_count), 64'h1);

        // Load mid-run at prescaler=2 restarts the tick phase.
        run = 1'b1;
        do_load(BLINK_H);
        cyc(8);
        check("mid_gen2",  64'(gen_count), 64'h2);
        check("mid_grid2", grid,           BLINK_H);
        cyc(2);
        do_load(BLOCK);
        check("mid_load_grid", grid,           BLOCK);
        check("mid_load_gen",  64'(gen_count), 64'h0);
        cyc(3);
        check("mid_pre_gen",   64'(gen_count), 64'h0);
        cyc(1);
        check("mid_adv_gen",   64'(gen_count), 64'h1);
        run = 1'b0;

        // Pause at prescaler=1, resume restarts the count; step ignored in RUN.
        do_load(BLINK_H);
        run = 1'b1;
        cyc(2);
        run = 1'b0;
        cyc(1);
        cyc(5);
        check("hold_grid", grid,           BLINK_H);
        check("hold_gen",  64'(gen_count), 64'h0);
        run  = 1'b1;
        cyc(1);
        step = 1'b1;
        cyc(3);
        step = 1'b0;
        check("resume_pre_gen", 64'(gen_count), 64'h0);
        cyc(1);
        check("resume_gen",  64'(gen_count), 64'h1);
        check("resume_grid", grid,           BLINK_V);
        cyc(2);
        #2;
        reset = 1'b1;
        #1;
        check("areset_grid",    grid,           64'h0);
        check("areset_gen",     64'(gen_count), 64'h0);
        check("areset_stable",  64'(stable),    64'h0);
        check("areset_extinct", 64'(extinct),   64'h1);
        run   = 1'b0;
        #1;
        reset = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
